control_riesgos: RTL and testbench

Hazard and stall controller for the 5-stage MIPS32 pipeline. Each cycle it decides whether the PC and the IF/ID register advance, hold or are flushed, and whether a bubble goes into ID/EX. It covers taken branches/jumps resolved in EX, load-use hazards and instruction-memory wait states. It sits beside the IF/ID and ID/EX registers and drives their enable/flush inputs. It also keeps a bubble counter and a memory-timeout flag.

---
 rtl/control_riesgos.sv | 114 +++++++++++
 tb/tb_control_riesgos.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_riesgos.sv
// Hazard/stall controller for the 5-stage MIPS32 pipeline: drives PC, IF/ID and ID/EX
// enables and flushes, and keeps a saturating bubble counter plus a sticky memory-timeout flag.
module control_riesgos #(
  parameter int ANCHO_CNT     = 16,
  parameter int LIMITE_ESPERA = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [4:0]           id_rs,
  input  logic [4:0]           id_rt,
  input  logic                 id_usa_rt,
  input  logic                 ex_memRead,
  input  logic [4:0]           ex_rt,
  input  logic                 ex_salto_tomado,
  input  logic                 imem_listo,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic [1:0]           estado,
  output logic [ANCHO_CNT-1:0] cnt_burbujas,
  output logic                 error_mem
);

  localparam int ANCHO_ESP  = $clog2(LIMITE_ESPERA + 1);
  localparam int ANCHO_SUMA = ANCHO_CNT + 1;
  localparam logic [ANCHO_CNT-1:0] CNT_MAX = '1;
  localparam logic [ANCHO_ESP-1:0] ESP_MAX = ANCHO_ESP'(LIMITE_ESPERA);

  typedef enum logic [1:0] {
    NORMAL     = 2'd0,
    BURBUJA    = 2'd1,
    ESPERA_MEM = 2'd2,
    INVALIDO   = 2'd3
  } estado_e;

  estado_e                estado_q, estado_d;
  logic [ANCHO_CNT-1:0]   cnt_q, cnt_d;
  logic [ANCHO_SUMA-1:0]  suma;
  logic [1:0]             incr;
  logic [ANCHO_ESP-1:0]   espera_q, espera_d;
  logic                   error_q, error_d;
  logic                   carga_uso;

  // The bubble slot itself must not re-detect the same load, or one load would stall twice.
  assign carga_uso = ex_memRead && (ex_rt != 5'd0)
                  && ((ex_rt == id_rs) || (id_usa_rt && (ex_rt == id_rt)))
                  && (estado_q != BURBUJA);

  always_comb begin
    // NOTE: every signal gets a default before the priority chain so no path leaves it unassigned and no latch is inferred.
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    incr        = 2'd0;
    estado_d    = NORMAL;

    if (ex_salto_tomado) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      incr        = 2'd2;
      estado_d    = imem_listo ? NORMAL : ESPERA_MEM;
    end else if (carga_uso) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      incr        = 2'd1;
      estado_d    = BURBUJA;
    end else if (!imem_listo) begin
      pc_write    = 1'b0;
      if_id_flush = 1'b1;
      incr        = 2'd1;
      estado_d    = ESPERA_MEM;
    end

    // Held in reset, the pipeline is frozen and both pipeline registers read as NOPs.
    if (!reset) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  // One extra carry bit turns saturation into a simple overflow test.
  assign suma  = {1'b0, cnt_q} + ANCHO_SUMA'(incr);
  assign cnt_d = suma[ANCHO_CNT] ? CNT_MAX : suma[ANCHO_CNT-1:0];

  assign espera_d = imem_listo            ? '0
                  : (espera_q == ESP_MAX) ? espera_q
                  :                         espera_q + ANCHO_ESP'(1);
  assign error_d  = error_q || (espera_d == ESP_MAX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= NORMAL;
      cnt_q    <= '0;
      espera_q <= '0;
      error_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      espera_q <= espera_d;
      error_q  <= error_d;
    end
  end

  assign estado       = estado_q;
  assign cnt_burbujas = cnt_q;
  assign error_mem    = error_q;

endmodule

// File: tb/tb_control_riesgos.sv
// Bench for control_riesgos: a hand-written vector table, randomized traffic against a
// rule-level reference model, and directed wait/timeout/saturation/reset sequences.
module tb_control_riesgos;

  localparam int LIM   = 64;
  localparam int LIM2  = 4;
  localparam int MAX1  = 65535;
  localparam int MAX2  = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_usa_rt, ex_memRead, ex_salto_tomado, imem_listo;

  logic        pc_write, if_id_write, if_id_flush, id_ex_flush;
  logic [1:0]  estado;
  logic [15:0] cnt_burbujas;
  logic        error_mem;

  logic        pc_write2, if_id_write2, if_id_flush2, id_ex_flush2;
  logic [1:0]  estado2;
  logic [1:0]  cnt2;
  logic        err2;

  control_riesgos dut (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_usa_rt(id_usa_rt),
    .ex_memRead(ex_memRead), .ex_rt(ex_rt), .ex_salto_tomado(ex_salto_tomado),
    .imem_listo(imem_listo), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .estado(estado),
    .cnt_burbujas(cnt_burbujas), .error_mem(error_mem)
  );

  control_riesgos #(.ANCHO_CNT(2), .LIMITE_ESPERA(LIM2)) dut2 (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_usa_rt(id_usa_rt),
    .ex_memRead(ex_memRead), .ex_rt(ex_rt), .ex_salto_tomado(ex_salto_tomado),
    .imem_listo(imem_listo), .pc_write(pc_write2), .if_id_write(if_id_write2),
    .if_id_flush(if_id_flush2), .id_ex_flush(id_ex_flush2), .estado(estado2),
    .cnt_burbujas(cnt2), .error_mem(err2)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       usa;
    logic       mr;
    logic [4:0] ert;
    logic       salto;
    logic       listo;
  } in_t;

  typedef struct {
    in_t        i;
    logic [3:0] ctl;   // {pc_write, if_id_write, if_id_flush, id_ex_flush}
    logic [1:0] est;
    int         cnt;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] s_ctl;

  // Reference model: remembers only whether the previous cycle was a load-use stall,
  // plus plain integer bubble/wait counts for both instances.
  bit m_stall_prev;
  int m_bub, m_bub2, m_wait, m_wait2;
  bit m_err, m_err2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic usa,
                             input logic mr, input logic [4:0] ert, input logic salto,
                             input logic listo);
    in_t v;
    v.rs = rs; v.rt = rt; v.usa = usa; v.mr = mr; v.ert = ert; v.salto = salto; v.listo = listo;
    return v;
  endfunction

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  // Called just after a rising edge; returns just after the next rising edge.
  task automatic cycle(input in_t v);
    bit         lu;
    logic [3:0] e;
    int         inc;
    int         e_est;
    id_rs = v.rs; id_rt = v.rt; id_usa_rt = v.usa; ex_memRead = v.mr;
    ex_rt = v.ert; ex_salto_tomado = v.salto; imem_listo = v.listo;

    lu = v.mr && (v.ert != 5'd0) && ((v.ert == v.rs) || (v.usa && (v.ert == v.rt))) && !m_stall_prev;
    if (v.salto)       begin e = 4'b1111; inc = 2; end
    else if (lu)       begin e = 4'b0001; inc = 1; end
    else if (!v.listo) begin e = 4'b0110; inc = 1; end
    else               begin e = 4'b1100; inc = 0; end
    e_est = (!v.salto && lu) ? 1 : (!v.listo ? 2 : 0);

    @(negedge clock);
    s_ctl = {pc_write, if_id_write, if_id_flush, id_ex_flush};
    check("ctl", 32'(s_ctl), 32'(e));
    check("ctl2", 32'({pc_write2, if_id_write2, if_id_flush2, id_ex_flush2}), 32'(e));

    @(posedge clock); #1;
    m_stall_prev = !v.salto && lu;
    m_bub   = sat(m_bub + inc, MAX1);
    m_bub2  = sat(m_bub2 + inc, MAX2);
    m_wait  = v.listo ? 0 : sat(m_wait + 1, LIM);
    m_wait2 = v.listo ? 0 : sat(m_wait2 + 1, LIM2);
    if (m_wait == LIM)   m_err  = 1'b1;
    if (m_wait2 == LIM2) m_err2 = 1'b1;

    check("estado", 32'(estado), 32'(e_est));
    check("estado2", 32'(estado2), 32'(e_est));
    check("cnt_burbujas", 32'(cnt_burbujas), 32'(m_bub));
    check("cnt2", 32'(cnt2), 32'(m_bub2));
    check("error_mem", 32'(error_mem), 32'(m_err));
    check("error_mem2", 32'(err2), 32'(m_err2));
  endtask

  // Called just after a rising edge; checks the asynchronous reset values mid-cycle.
  task automatic do_reset();
    reset = 1'b0;
    #2;
    check("rst_ctl", 32'({pc_write, if_id_write, if_id_flush, id_ex_flush}), 32'(4'b0011));
    check("rst_estado", 32'(estado), 32'd0);
    check("rst_cnt", 32'(cnt_burbujas), 32'd0);
    check("rst_err", 32'(error_mem), 32'd0);
    check("rst_cnt2", 32'(cnt2), 32'd0);
    check("rst_err2", 32'(err2), 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    m_stall_prev = 1'b0;
    m_bub = 0; m_bub2 = 0; m_wait = 0; m_wait2 = 0; m_err = 1'b0; m_err2 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    vec_t r;
    in_t  v;
    in_t  idle;
    int   sat_exp[3];

    id_rs = '0; id_rt = '0; id_usa_rt = 1'b0; ex_memRead = 1'b0;
    ex_rt = '0; ex_salto_tomado = 1'b0; imem_listo = 1'b1;
    idle = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);

    @(posedge clock); #1;
    do_reset();

    // rs, rt, usa_rt, memRead, ex_rt, salto, listo -> ctl, next estado, cnt_burbujas
    r.i = mk(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1); r.ctl = 4'b0001; r.est = 2'd1; r.cnt = 1;  vecs.push_back(r);
    r.i = mk(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1); r.ctl = 4'b1100; r.est = 2'd0; r.cnt = 1;  vecs.push_back(r);
    r.i = mk(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1); r.ctl = 4'b1100; r.est = 2'd0; r.cnt = 1;  vecs.push_back(r);
    r.i = mk(5'd1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1); r.ctl = 4'b1100; r.est = 2'd0; r.cnt = 1;  vecs.push_back(r);
    r.i = mk(5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1); r.ctl = 4'b0001; r.est = 2'd1; r.cnt = 2;  vecs.push_back(r);
    r.i = mk(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1); r.ctl = 4'b1111; r.est = 2'd0; r.cnt = 4;  vecs.push_back(r);
    r.i = mk(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1); r.ctl = 4'b1111; r.est = 2'd0; r.cnt = 6;  vecs.push_back(r);
    r.i = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0); r.ctl = 4'b0110; r.est = 2'd2; r.cnt = 7;  vecs.push_back(r);
    r.i = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0); r.ctl = 4'b0110; r.est = 2'd2; r.cnt = 8;  vecs.push_back(r);
    r.i = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1); r.ctl = 4'b1100; r.est = 2'd0; r.cnt = 8;  vecs.push_back(r);
    r.i = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0); r.ctl = 4'b1111; r.est = 2'd2; r.cnt = 10; vecs.push_back(r);
    r.i = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1); r.ctl = 4'b1111; r.est = 2'd0; r.cnt = 12; vecs.push_back(r);
    r.i = mk(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0); r.ctl = 4'b0001; r.est = 2'd1; r.cnt = 13; vecs.push_back(r);
    r.i = mk(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0); r.ctl = 4'b0110; r.est = 2'd2; r.cnt = 14; vecs.push_back(r);
    r.i = mk(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1); r.ctl = 4'b0001; r.est = 2'd1; r.cnt = 15; vecs.push_back(r);
    r.i = mk(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1); r.ctl = 4'b1100; r.est = 2'd0; r.cnt = 15; vecs.push_back(r);

    foreach (vecs[k]) begin
      cycle(vecs[k].i);
      check("tbl_ctl", 32'(s_ctl), 32'(vecs[k].ctl));
      check("tbl_estado", 32'(estado), 32'(vecs[k].est));
      check("tbl_cnt", 32'(cnt_burbujas), 32'(vecs[k].cnt));
    end

    // Randomized traffic with occasional resets landing mid-stall.
    for (int n = 0; n < 400; n++) begin
      v.rs    = 5'($urandom_range(0, 3));
      v.rt    = 5'($urandom_range(0, 3));
      v.usa   = 1'($urandom_range(0, 1));
      v.mr    = 1'($urandom_range(0, 1));
      v.ert   = 5'($urandom_range(0, 3));
      v.salto = ($urandom_range(0, 7) == 0);
      v.listo = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 63) == 0) do_reset();
      cycle(v);
    end

    // Bubble-counter saturation on the 2-bit instance: 0 -> 2 -> 3 -> 3.
    do_reset();
    sat_exp[0] = 2; sat_exp[1] = 3; sat_exp[2] = 3;
    for (int k = 0; k < 3; k++) begin
      cycle(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1));
      check("sat_cnt2", 32'(cnt2), 32'(sat_exp[k]));
    end

    // Three wait cycles, then release with the PC advancing.
    do_reset();
    for (int k = 0; k < 3; k++) cycle(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0));
    check("wait3_cnt", 32'(cnt_burbujas), 32'd3);
    check("wait3_estado", 32'(estado), 32'd2);
    cycle(idle);
    check("release_pc", 32'(s_ctl[3]), 32'd1);
    check("release_estado", 32'(estado), 32'd0);

    // Taken branch during a wait redirects at once but does not clear the wait count.
    do_reset();
    for (int k = 0; k < 3; k++) cycle(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0));
    cycle(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0));
    check("salto_wait_pc", 32'(s_ctl[3]), 32'd1);
    check("salto_wait_err2", 32'(err2), 32'd1);

    // Memory timeout: the flag sets on the 64th consecutive not-ready edge and is sticky.
    do_reset();
    for (int k = 0; k < LIM - 1; k++) cycle(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0));
    check("timeout_before", 32'(error_mem), 32'd0);
    cycle(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0));
    check("timeout_set", 32'(error_mem), 32'd1);
    cycle(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0));
    check("timeout_still_stalls", 32'(s_ctl[3]), 32'd0);
    cycle(idle);
    check("timeout_sticky", 32'(error_mem), 32'd1);

    // Reset in the bubble cycle forgets the stall: the same load-use stalls again.
    cycle(mk(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1));
    do_reset();
    cycle(mk(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1));
    check("rst_mid_stall_estado", 32'(estado), 32'd1);
    check("rst_mid_stall_cnt", 32'(cnt_burbujas), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
